// File: rtl/dsp_loader_if.sv
// ---------------------------------------------------------------------------
// dsp_loader_if
//
// Bundles every non-clock/non-reset signal of the dsp_loader sequencer:
//   command   : start, base_addr, count          (controller -> loader)
//   memory    : mem_addr -> , <- mem_rdata        (1-cycle read latency)
//   dsp       : dsp_din, dsp_we, dsp_param -> , <- dsp_dout
//   result    : result_data, result_valid -> , <- result_ready
//   status    : busy, done, state_dbg (FSM state for observation)
//
// Handshake rule for the result port: a result transfers on every rising
// clk edge where result_valid and result_ready are both high; while valid is
// high and ready is low, result_data and result_valid stay stable.
//
// Modports:
//   master : the dsp_loader itself
//   slave  : the surrounding system (controller, memory, dsp, consumer)
// ---------------------------------------------------------------------------
interface dsp_loader_if #(
    parameter int bus_width    = 24,
    parameter int sample_width = 14
) ();
    logic                    start;
    logic [5:0]              base_addr;
    logic [5:0]              count;
    logic [5:0]              mem_addr;
    logic [sample_width-1:0] mem_rdata;
    logic [bus_width-1:0]    dsp_din;
    logic                    dsp_we;
    logic [7:0]              dsp_param;
    logic [bus_width-1:0]    dsp_dout;
    logic [bus_width-1:0]    result_data;
    logic                    result_valid;
    logic                    result_ready;
    logic                    busy;
    logic                    done;
    logic [2:0]              state_dbg;

    modport master (
        input  start, base_addr, count, mem_rdata, dsp_dout, result_ready,
        output mem_addr, dsp_din, dsp_we, dsp_param, result_data,
               result_valid, busy, done, state_dbg
    );

    modport slave (
        output start, base_addr, count, mem_rdata, dsp_dout, result_ready,
        input  mem_addr, dsp_din, dsp_we, dsp_param, result_data,
               result_valid, busy, done, state_dbg
    );
endinterface

// File: rtl/dsp_loader.sv
// ---------------------------------------------------------------------------
// dsp_loader
//
// Sequencer sitting between a 64-entry sample RAM and the dsp block.
// On an accepted start it streams count samples (starting at base_addr,
// wrapping modulo 64) from the RAM into the dsp shift register, sign
// extending each sample to bus width. It then sweeps the dsp tap select
// from 0 to num_taps-1 and hands every tap value out on a valid/ready port.
//
// Ports:
//   clk   : system clock, everything on the rising edge
//   rstn  : synchronous active-low reset
//   bus   : dsp_loader_if.master (command, memory, dsp, result, status)
//
// Timing summary:
//   start accepted at edge N  -> mem_addr = base from N, first dsp_we at N+1
//   each LOAD cycle issues one address; the matching write follows one cycle
//   later, so the write stream trails the address stream by exactly one cycle
//   and the FLUSH state covers the trailing write of the last sample.
// ---------------------------------------------------------------------------
module dsp_loader #(
    parameter int bus_width    = 24,
    parameter int sample_width = 14,
    parameter int num_taps     = 2
) (
    input  logic          clk,
    input  logic          rstn,
    dsp_loader_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_FLUSH   = 3'd2,
        S_RD_SET  = 3'd3,
        S_RD_WAIT = 3'd4,
        S_CAPTURE = 3'd5,
        S_EMIT    = 3'd6,
        S_DONE    = 3'd7
    } state_e;

    localparam logic [7:0] LAST_TAP = 8'(num_taps - 1);

    state_e               state_q, state_d;
    logic [5:0]           cnt_q, cnt_d;        // latched sample count
    logic [5:0]           idx_q, idx_d;        // sample index within the run
    logic [5:0]           addr_q, addr_d;      // memory address register
    logic [7:0]           tap_q, tap_d;        // current tap select
    logic                 wr_valid_q, wr_valid_d;
    logic [bus_width-1:0] res_q, res_d;
    logic                 res_valid_q, res_valid_d;
    logic [bus_width-1:0] din_sext;

    // Sign extension; a sized cast of a signed operand replicates the MSB,
    // which also covers sample_width == bus_width without a zero replication.
    assign din_sext = bus_width'($signed(bus.mem_rdata));

    // -----------------------------------------------------------------------
    // Next-state and datapath control
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        tap_d       = tap_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        // A write is due exactly one cycle after every LOAD address, because
        // the RAM returns data one cycle after the address.
        wr_valid_d  = (state_q == S_LOAD);

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    cnt_d = bus.count;
                    idx_d = 6'd0;
                    tap_d = 8'd0;
                    if (bus.count != 6'd0) begin
                        // Address 0 of the run is presented in the first
                        // LOAD cycle; mem_addr is untouched for empty runs.
                        addr_d  = bus.base_addr;
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_RD_SET;
                    end
                end
            end

            S_LOAD: begin
                if (idx_q == cnt_q - 6'd1) begin
                    state_d = S_FLUSH;
                end else begin
                    idx_d  = idx_q + 6'd1;
                    addr_d = addr_q + 6'd1;   // natural 6-bit wrap
                end
            end

            // Covers the write of the last sample; the first tap select is
            // therefore applied only after the final shift has happened.
            S_FLUSH: begin
                state_d = S_RD_SET;
            end

            S_RD_SET: begin
                state_d = S_RD_WAIT;
            end

            S_RD_WAIT: begin
                state_d = S_CAPTURE;
            end

            S_CAPTURE: begin
                res_d       = bus.dsp_dout;
                res_valid_d = 1'b1;
                state_d     = S_EMIT;
            end

            S_EMIT: begin
                if (bus.result_ready) begin
                    res_valid_d = 1'b0;
                    if (tap_q != LAST_TAP) begin
                        tap_d   = tap_q + 8'd1;
                        state_d = S_RD_SET;
                    end else begin
                        tap_d   = 8'd0;
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                // start is deliberately not looked at here
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            cnt_q       <= 6'd0;
            idx_q       <= 6'd0;
            addr_q      <= 6'd0;
            tap_q       <= 8'd0;
            wr_valid_q  <= 1'b0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            tap_q       <= tap_d;
            wr_valid_q  <= wr_valid_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.mem_addr     = addr_q;
    assign bus.dsp_we       = wr_valid_q;
    // Gated so dsp_din is 0 whenever no write is in progress (incl. reset).
    assign bus.dsp_din      = wr_valid_q ? din_sext : '0;
    assign bus.dsp_param    = tap_q;
    assign bus.result_data  = res_q;
    assign bus.result_valid = res_valid_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = (state_q == S_DONE);
    assign bus.state_dbg    = state_q;

endmodule
